// File: rtl/coprocessor_pio_pkg.sv
// Shared definitions for the coprocessor PIO ports: register map and edge encodings.
package coprocessor_pio_pkg;

  // Word addresses of the slave registers
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  // Edge-type selection for the capture logic
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Decoded bus request for one cycle
  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/coprocessor_status_in_if.sv
// Avalon-MM slave bus bundle for the coprocessor status input port.
interface coprocessor_status_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/pio_sync_edge.sv
// Multi-flop synchronizer for an asynchronous bus plus per-bit edge detection.
module pio_sync_edge
  import coprocessor_pio_pkg::*;
#(
  parameter int WIDTH       = 15,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_q,
  output logic [WIDTH-1:0] edge_det
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_d, stage_q;
  logic [WIDTH-1:0]                  prev_d, prev_q;

  // Shift the async bus one stage per clock; prev tracks the synchronized value one clock late
  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = async_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    prev_d = sync_q;
  end

  // Synchronizer chain and previous-sample register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_q <= '0;
      prev_q  <= '0;
    end else begin
      stage_q <= stage_d;
      prev_q  <= prev_d;
    end
  end

  assign sync_q = stage_q[SYNC_STAGES-1];

  // Only the selected edge term is built so unused terms never appear
  if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
    assign edge_det = ~sync_q & prev_q;
  end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
    assign edge_det = (sync_q & ~prev_q) | (~sync_q & prev_q);
  end else begin : g_rise
    assign edge_det = sync_q & ~prev_q;
  end

endmodule

// File: rtl/coprocessor_status_in.sv
// Avalon-MM input port: live status read, edge capture with W1C clear, maskable level irq.
module coprocessor_status_in
  import coprocessor_pio_pkg::*;
#(
  parameter int WIDTH       = 15,
  parameter int EDGE_TYPE   = EDGE_RISING,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [WIDTH-1:0]        in_port,
  coprocessor_status_in_if.slave  bus
);

  bus_req_t         req;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] irqmask_d, irqmask_q;
  logic [WIDTH-1:0] edgecap_d, edgecap_q;
  logic [WIDTH-1:0] edge_clr;
  logic [31:0]      rd_mux;
  logic [31:0]      readdata_d, readdata_q;
  logic             irq_d, irq_q;

  pio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (in_port),
    .sync_q   (sync_q),
    .edge_det (edge_det)
  );

  // Decode the strobes into a single request; the slave never stalls
  always_comb begin
    req.rd    = bus.chipselect & ~bus.read_n;
    req.wr    = bus.chipselect & ~bus.write_n;
    req.addr  = bus.address;
    req.wdata = bus.writedata;
  end

  // Register updates: mask load, W1C capture where a fresh edge beats the clear
  always_comb begin
    irqmask_d = irqmask_q;
    if (req.wr && req.addr == ADDR_IRQMASK) begin
      irqmask_d = req.wdata[WIDTH-1:0];
    end
    edge_clr = '0;
    if (req.wr && req.addr == ADDR_EDGECAP) begin
      edge_clr = req.wdata[WIDTH-1:0];
    end
    edgecap_d = (edgecap_q & ~edge_clr) | edge_det;
    irq_d     = |(edgecap_q & irqmask_q);
  end

  // Read mux uses current register values, so a same-cycle write is not seen by the read
  always_comb begin
    rd_mux = '0;
    case (req.addr)
      ADDR_DATA:    rd_mux[WIDTH-1:0] = sync_q;
      ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask_q;
      ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edgecap_q;
      default:      rd_mux = '0;
    endcase
    readdata_d = req.rd ? rd_mux : readdata_q;
  end

  // Register file, read data and irq flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = irq_q;

endmodule

// File: tb/tb_coprocessor_status_in.sv
// Scoreboard bench: three DUTs (rising/falling/any) share one stimulus stream.
module tb_coprocessor_status_in;

  localparam int W = 15;
  localparam int S = 2;

  typedef logic [2:0][31:0] trio_t;

  logic          clk;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          read_n;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   rd_w  [3];
  logic          irq_w [3];

  int asserts  = 0;
  int failures = 0;

  trio_t      exp_rd  [$];
  logic [2:0] exp_irq [$];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    coprocessor_status_in_if bus_if ();
    assign bus_if.address    = address;
    assign bus_if.chipselect = chipselect;
    assign bus_if.read_n     = read_n;
    assign bus_if.write_n    = write_n;
    assign bus_if.writedata  = writedata;
    coprocessor_status_in #(
      .WIDTH       (W),
      .EDGE_TYPE   (gi),
      .SYNC_STAGES (S)
    ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .in_port (in_port),
      .bus     (bus_if.slave)
    );
    assign rd_w[gi]  = bus_if.readdata;
    assign irq_w[gi] = bus_if.irq;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] m_sync, m_prev, m_mask;
  logic [W-1:0] m_cap [3];
  logic [W-1:0] m_pipe [$];

  task automatic model_reset();
    m_sync = '0; m_prev = '0; m_mask = '0;
    for (int k = 0; k < 3; k++) m_cap[k] = '0;
    m_pipe.delete();
    for (int k = 0; k < S; k++) m_pipe.push_back('0);
    exp_rd.delete();
    exp_irq.delete();
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        model_reset();
      end else begin
        bit rd, wr;
        trio_t er;
        logic [2:0] ei;
        logic [W-1:0] clr, rise, fall;
        rd = chipselect && !read_n;
        wr = chipselect && !write_n;
        for (int k = 0; k < 3; k++) begin
          case (address)
            2'd0:    er[k] = 32'(m_sync);
            2'd2:    er[k] = 32'(m_mask);
            2'd3:    er[k] = 32'(m_cap[k]);
            default: er[k] = 32'd0;
          endcase
          ei[k] = |(m_cap[k] & m_mask);
        end
        if (rd) exp_rd.push_back(er);
        exp_irq.push_back(ei);
        clr  = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
        rise = m_sync & ~m_prev;
        fall = ~m_sync & m_prev;
        m_cap[0] = (m_cap[0] & ~clr) | rise;
        m_cap[1] = (m_cap[1] & ~clr) | fall;
        m_cap[2] = (m_cap[2] & ~clr) | rise | fall;
        if (wr && address == 2'd2) m_mask = writedata[W-1:0];
        m_prev = m_sync;
        m_pipe.push_back(in_port);
        void'(m_pipe.pop_front());
        m_sync = m_pipe[0];
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      bit live, rd;
      @(posedge clk);
      live = (reset_n === 1'b1);
      rd   = live && chipselect && !read_n;
      #1;
      if (live && reset_n) begin
        if (exp_irq.size() == 0) begin
          check("irq_underflow", 32'd1, 32'd0);
        end else begin
          logic [2:0] ei;
          ei = exp_irq.pop_front();
          for (int k = 0; k < 3; k++) check($sformatf("irq_t%0d", k), 32'(irq_w[k]), 32'(ei[k]));
        end
        if (rd) begin
          if (exp_rd.size() == 0) begin
            check("rd_underflow", 32'd1, 32'd0);
          end else begin
            trio_t er;
            er = exp_rd.pop_front();
            for (int k = 0; k < 3; k++) begin
              check($sformatf("readdata_t%0d_a%0d", k, address), rd_w[k], er[k]);
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic bus_op(input logic [1:0] a, input bit cs, input bit rd, input bit wr, input logic [31:0] wd);
    @(negedge clk);
    address    = a;
    chipselect = cs;
    read_n     = !rd;
    write_n    = !wr;
    writedata  = wd;
    $display("txn t=%0t addr=%0d cs=%0d rd=%0d wr=%0d wdata=0x%08h in_port=0x%04h",
             $time, a, cs, rd, wr, wd, in_port);
  endtask

  task automatic idle(input int n);
    repeat (n) bus_op(2'd0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic rd_reg(input logic [1:0] a);
    bus_op(a, 1'b1, 1'b1, 1'b0, 32'd0);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] wd);
    bus_op(a, 1'b1, 1'b0, 1'b1, wd);
  endtask

  task automatic do_reset(input logic [W-1:0] v);
    @(negedge clk);
    reset_n    = 1'b0;
    in_port    = v;
    chipselect = 1'b0;
    read_n     = 1'b1;
    write_n    = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_irq_t%0d", k), 32'(irq_w[k]), 32'd0);
      check($sformatf("reset_readdata_t%0d", k), rd_w[k], 32'd0);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    $display("txn t=%0t reset released in_port=0x%04h", $time, v);
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    read_n     = 1'b1;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '0;

    // Reset with in_port held high, then read DATA/IRQMASK/EDGECAPTURE
    do_reset(15'h7FFF);
    idle(4);
    rd_reg(2'd0);
    rd_reg(2'd2);
    rd_reg(2'd3);
    rd_reg(2'd1);
    idle(2);

    // Synchronizer latency: continuous reads of DATA while in_port changes
    wr_reg(2'd3, 32'hFFFF);
    in_port = '0;
    idle(4);
    wr_reg(2'd3, 32'hFFFF);
    rd_reg(2'd0);
    in_port = 15'h0005;
    repeat (6) rd_reg(2'd0);

    // Edge capture and irq on bit 2, then W1C clear
    in_port = '0;
    idle(4);
    wr_reg(2'd3, 32'hFFFF);
    wr_reg(2'd2, 32'h0004);
    in_port = 15'h0004;
    idle(1);
    in_port = '0;
    repeat (5) rd_reg(2'd3);
    wr_reg(2'd3, 32'h0004);
    repeat (4) rd_reg(2'd3);

    // Mask isolation on bit 3
    wr_reg(2'd3, 32'hFFFF);
    wr_reg(2'd2, 32'h0001);
    in_port = 15'h0008;
    idle(1);
    in_port = '0;
    repeat (5) rd_reg(2'd3);
    wr_reg(2'd2, 32'h0009);
    repeat (3) rd_reg(2'd2);

    // Clear/set collision on bit 1
    idle(4);
    wr_reg(2'd3, 32'hFFFF);
    idle(1);
    in_port = 15'h0002;
    idle(1);
    wr_reg(2'd3, 32'hFFFF);
    repeat (2) rd_reg(2'd3);
    in_port = '0;
    idle(4);

    // Edge-type sweep on bit 0: 0 -> 1 -> 0, clearing after each edge
    wr_reg(2'd3, 32'hFFFF);
    in_port = 15'h0001;
    idle(4);
    rd_reg(2'd3);
    wr_reg(2'd3, 32'hFFFF);
    rd_reg(2'd3);
    in_port = '0;
    idle(4);
    rd_reg(2'd3);
    wr_reg(2'd3, 32'hFFFF);
    rd_reg(2'd3);
    rd_reg(2'd3);

    // Read while writing the same address returns the old value
    wr_reg(2'd2, 32'h0000);
    bus_op(2'd2, 1'b1, 1'b1, 1'b1, 32'h7ABC);
    rd_reg(2'd2);

    // Randomized traffic with occasional mid-operation reset
    repeat (800) begin
      int sel;
      if ($urandom_range(0, 3) == 0) in_port = W'($urandom);
      sel = $urandom_range(0, 99);
      if (sel == 0) begin
        do_reset(W'($urandom));
      end else if (sel < 45) begin
        rd_reg(2'($urandom_range(0, 3)));
      end else if (sel < 80) begin
        wr_reg(2'($urandom_range(0, 3)), $urandom);
      end else if (sel < 90) begin
        bus_op(2'($urandom_range(0, 3)), 1'b1, 1'b1, 1'b1, $urandom);
      end else begin
        bus_op(2'($urandom_range(0, 3)), 1'b0, 1'($urandom), 1'($urandom), $urandom);
      end
    end

    idle(4);
    check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
